// File: rtl/bp_common_pkg.sv
// -----------------------------------------------------------------------------
// bp_common_pkg
// Shared types and helpers for the NTT datapath blocks.
//   alu_op_e         : ntt_alu operation codes
//   ntt_bank_sel_t   : 2-bit coefficient bank select {poly, parity}
//   NTT_NUM_BANKS    : number of coefficient banks (two polys x even/odd)
//   ntt_coeff_map()  : logical coefficient index -> {bank, word address}
// -----------------------------------------------------------------------------
package bp_common_pkg;

  typedef enum logic [1:0] {
    ALU_OP_NTT  = 2'd0,
    ALU_OP_INTT = 2'd1,
    ALU_OP_PWM  = 2'd2,
    ALU_OP_ADD  = 2'd3
  } alu_op_e;

  typedef logic [1:0] ntt_bank_sel_t;

  localparam int NTT_NUM_BANKS = 4;

  // Widest supported polynomial; the map helper is sized for it and callers
  // with a smaller max_logn zero-extend the index and use the low address bits.
  localparam int NTT_MAX_LOGN = 12;

  typedef struct packed {
    ntt_bank_sel_t                 bank;
    logic [NTT_MAX_LOGN-2:0]       addr;
  } ntt_coeff_loc_t;

  // Even/odd coefficients live in separate banks so a butterfly pair can be
  // fetched in one cycle.
  function automatic ntt_coeff_loc_t ntt_coeff_map(input logic poly,
                                                   input logic [NTT_MAX_LOGN-1:0] idx);
    ntt_coeff_loc_t loc;
    loc.bank = {poly, idx[0]};
    loc.addr = idx[NTT_MAX_LOGN-1:1];
    return loc;
  endfunction

endpackage

// File: rtl/ntt_bank_ram.sv
// -----------------------------------------------------------------------------
// ntt_bank_ram
// One coefficient bank: 1 write port + 1 read port, synchronous read.
// A read and write to the same address in the same cycle returns the old word.
// Contents are not reset.
//   clk      : clock
//   wr_en    : write enable (commit at rising edge)
//   wr_addr  : write word address
//   wr_data  : write word
//   rd_en    : read enable; rd_data updates on the next edge, holds otherwise
//   rd_addr  : read word address
//   rd_data  : registered read word
// -----------------------------------------------------------------------------
module ntt_bank_ram #(
  parameter int addr_w = 11,
  parameter int data_w = 30
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [data_w-1:0] wr_data,
  input  logic              rd_en,
  input  logic [addr_w-1:0] rd_addr,
  output logic [data_w-1:0] rd_data
);

  logic [data_w-1:0] mem [2**addr_w];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ntt_poly_mem.sv
// -----------------------------------------------------------------------------
// ntt_poly_mem
// Banked coefficient memory for two polynomials, serving the ntt_alu memory
// master (2 read + 2 write ports, 1-cycle read latency) and a valid/ready host
// load/unload port that is only granted while the ALU is idle.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   r_addr_x/r_bank_x/r_en_x   : ALU read ports; r_data_x valid 1 cycle later
//   w_addr_x/w_bank_x/w_en_x/w_data_x : ALU write ports
//   alu_done                   : ALU idle; host access allowed while high
//   host_wr_*                  : host coefficient write (valid/ready)
//   host_rd_req_*              : host read request (valid/ready)
//   host_rd_resp_*             : host read response (valid/ready), 2-deep buffer
//   err_conflict               : sticky collision/misuse flag
// Build option:
//   NTT_MEM_CONFLICT_CHK_EN    : enables err_conflict detection; when undefined
//                                err_conflict is tied low.
// Port 0 always wins a same-bank collision; port 1's access is dropped.
// -----------------------------------------------------------------------------
module ntt_poly_mem
  import bp_common_pkg::*;
#(
  parameter int max_logn = NTT_MAX_LOGN,
  parameter int max_logq = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [max_logn-2:0] r_addr_0,
  input  logic [max_logn-2:0] r_addr_1,
  input  logic [1:0]          r_bank_0,
  input  logic [1:0]          r_bank_1,
  input  logic                r_en_0,
  input  logic                r_en_1,
  output logic [max_logq-1:0] r_data_0,
  output logic [max_logq-1:0] r_data_1,
  input  logic [max_logn-2:0] w_addr_0,
  input  logic [max_logn-2:0] w_addr_1,
  input  logic [1:0]          w_bank_0,
  input  logic [1:0]          w_bank_1,
  input  logic                w_en_0,
  input  logic                w_en_1,
  input  logic [max_logq-1:0] w_data_0,
  input  logic [max_logq-1:0] w_data_1,
  input  logic                alu_done,
  input  logic                host_wr_valid,
  output logic                host_wr_ready,
  input  logic                host_wr_poly,
  input  logic [max_logn-1:0] host_wr_idx,
  input  logic [max_logq-1:0] host_wr_data,
  input  logic                host_rd_req_valid,
  output logic                host_rd_req_ready,
  input  logic                host_rd_req_poly,
  input  logic [max_logn-1:0] host_rd_req_idx,
  output logic                host_rd_resp_valid,
  input  logic                host_rd_resp_ready,
  output logic [max_logq-1:0] host_rd_resp_data,
  output logic                err_conflict
);

  localparam int AW = max_logn - 1;

  // ---------------------------------------------------------------------------
  // Host gating
  // ---------------------------------------------------------------------------
  logic           any_alu_en;
  logic           host_busy_n;
  logic           active_reg;      // keeps host readies low until out of reset
  logic           host_wr_fire;
  logic           host_rd_fire;
  ntt_coeff_loc_t hwr_loc;
  ntt_coeff_loc_t hrd_loc;

  assign any_alu_en   = r_en_0 | r_en_1 | w_en_0 | w_en_1;
  assign host_busy_n  = alu_done & ~any_alu_en & active_reg;
  assign host_wr_ready = host_busy_n;
  assign host_wr_fire  = host_wr_valid & host_wr_ready;
  assign host_rd_fire  = host_rd_req_valid & host_rd_req_ready;

  assign hwr_loc = ntt_coeff_map(host_wr_poly, NTT_MAX_LOGN'(host_wr_idx));
  assign hrd_loc = ntt_coeff_map(host_rd_req_poly, NTT_MAX_LOGN'(host_rd_req_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg <= 1'b0;
    end else begin
      active_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Banks: per-bank port arbitration, ALU port 0 > ALU port 1 > host.
  // Host only fires when no ALU enable is high, so it never displaces the ALU.
  // ---------------------------------------------------------------------------
  logic [max_logq-1:0] b_rdata [NTT_NUM_BANKS];

  for (genvar gi = 0; gi < NTT_NUM_BANKS; gi++) begin : g_bank
    localparam ntt_bank_sel_t BANK = ntt_bank_sel_t'(gi);

    logic                we;
    logic                re;
    logic [AW-1:0]       waddr;
    logic [AW-1:0]       raddr;
    logic [max_logq-1:0] wdata;

    always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      if (w_en_0 && (w_bank_0 == BANK)) begin
        we    = 1'b1;
        waddr = w_addr_0;
        wdata = w_data_0;
      end else if (w_en_1 && (w_bank_1 == BANK)) begin
        we    = 1'b1;
        waddr = w_addr_1;
        wdata = w_data_1;
      end else if (host_wr_fire && (hwr_loc.bank == BANK)) begin
        we    = 1'b1;
        waddr = hwr_loc.addr[AW-1:0];
        wdata = host_wr_data;
      end

      re    = 1'b0;
      raddr = '0;
      if (r_en_0 && (r_bank_0 == BANK)) begin
        re    = 1'b1;
        raddr = r_addr_0;
      end else if (r_en_1 && (r_bank_1 == BANK)) begin
        re    = 1'b1;
        raddr = r_addr_1;
      end else if (host_rd_fire && (hrd_loc.bank == BANK)) begin
        re    = 1'b1;
        raddr = hrd_loc.addr[AW-1:0];
      end
    end

    ntt_bank_ram #(
      .addr_w (AW),
      .data_w (max_logq)
    ) u_ram (
      .clk     (clk),
      .wr_en   (we),
      .wr_addr (waddr),
      .wr_data (wdata),
      .rd_en   (re),
      .rd_addr (raddr),
      .rd_data (b_rdata[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // ALU read return. The bank register is shared with other requesters, so
  // each port remembers which bank it read last cycle and otherwise replays
  // its own held copy.
  // ---------------------------------------------------------------------------
  logic                rd1_collide;
  logic                rd_vld_0_reg, rd_vld_1_reg;
  ntt_bank_sel_t       rd_sel_0_reg, rd_sel_1_reg;
  logic [max_logq-1:0] r_hold_0_reg, r_hold_1_reg;

  assign rd1_collide = r_en_0 & r_en_1 & (r_bank_0 == r_bank_1);

  assign r_data_0 = rd_vld_0_reg ? b_rdata[rd_sel_0_reg] : r_hold_0_reg;
  assign r_data_1 = rd_vld_1_reg ? b_rdata[rd_sel_1_reg] : r_hold_1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_0_reg <= 1'b0;
      rd_vld_1_reg <= 1'b0;
      rd_sel_0_reg <= '0;
      rd_sel_1_reg <= '0;
      r_hold_0_reg <= '0;
      r_hold_1_reg <= '0;
    end else begin
      rd_vld_0_reg <= r_en_0;
      rd_vld_1_reg <= r_en_1 & ~rd1_collide;
      rd_sel_0_reg <= r_bank_0;
      rd_sel_1_reg <= r_bank_1;
      r_hold_0_reg <= r_data_0;
      r_hold_1_reg <= r_data_1;
    end
  end

  // ---------------------------------------------------------------------------
  // Host read response path. The word read at the accept edge is shown
  // directly from the bank register while the buffer is empty (1-cycle
  // latency) and is captured into the 2-entry buffer unless popped right away.
  // ---------------------------------------------------------------------------
  logic                inflight_reg;
  ntt_bank_sel_t       hrd_bank_reg;
  logic [1:0]          count_reg;
  logic                wr_ptr_reg, rd_ptr_reg;
  logic [max_logq-1:0] fifo_mem [2];
  logic                fifo_nonempty;
  logic                resp_fire;
  logic                buf_push;
  logic                buf_pop;
  logic [max_logq-1:0] inflight_data;

  assign fifo_nonempty     = (count_reg != 2'd0);
  assign inflight_data     = b_rdata[hrd_bank_reg];
  assign host_rd_resp_valid = fifo_nonempty | inflight_reg;
  assign host_rd_resp_data  = fifo_nonempty ? fifo_mem[rd_ptr_reg] :
                              inflight_reg  ? inflight_data : '0;
  assign resp_fire = host_rd_resp_valid & host_rd_resp_ready;
  assign buf_push  = inflight_reg & ~(resp_fire & ~fifo_nonempty);
  assign buf_pop   = resp_fire & fifo_nonempty;

  assign host_rd_req_ready = host_busy_n &
                             ((count_reg + {1'b0, inflight_reg}) < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= 1'b0;
      hrd_bank_reg <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      inflight_reg <= host_rd_fire;
      if (host_rd_fire) begin
        hrd_bank_reg <= hrd_loc.bank;
      end
      if (buf_push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (buf_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + 2'(buf_push) - 2'(buf_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_push) begin
      fifo_mem[wr_ptr_reg] <= inflight_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Collision / misuse flag
  // ---------------------------------------------------------------------------
`ifdef NTT_MEM_CONFLICT_CHK_EN
  logic wr1_collide;
  logic conflict_now;
  logic err_reg;

  assign wr1_collide  = w_en_0 & w_en_1 & (w_bank_0 == w_bank_1);
  assign conflict_now = rd1_collide | wr1_collide | (alu_done & any_alu_en);
  assign err_conflict = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (conflict_now) begin
      err_reg <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && conflict_now) begin
      $error("ntt_poly_mem: bank conflict or ALU access while alu_done");
    end
  end
`endif
`else
  assign err_conflict = 1'b0;
`endif

endmodule

// File: doc/ntt_poly_mem.md
Name: ntt_poly_mem

Overview:
Banked coefficient memory that serves as the responder to the ntt_alu memory-master ports. It holds two polynomials in 4 banks, with bank = {poly, coeff_idx[0]}. It answers the ALU's two read ports with 1-cycle latency and commits its two write ports. A valid/ready host port loads and unloads coefficients whenever the ALU is idle.

Parameters:
max_logn, 12, log2 of max polynomial length; each bank holds 2^(max_logn-1) words
max_logq, 30, coefficient width in bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
r_addr_0, r_addr_1  in  max_logn-1  ALU read word address per port
r_bank_0, r_bank_1  in  2  ALU read bank select {poly, parity}
r_en_0, r_en_1  in  1  ALU read enables
r_data_0, r_data_1  out  max_logq  read data, valid 1 cycle after r_en
w_addr_0, w_addr_1  in  max_logn-1  ALU write word address
w_bank_0, w_bank_1  in  2  ALU write bank select
w_en_0, w_en_1  in  1  ALU write enables
w_data_0, w_data_1  in  max_logq  ALU write data
alu_done  in  1  ntt_alu done (idle); host access is allowed only while high
host_wr_valid / host_wr_ready  in / out  1  host write handshake
host_wr_poly  in  1  target polynomial
host_wr_idx  in  max_logn  logical coefficient index
host_wr_data  in  max_logq  coefficient
host_rd_req_valid / host_rd_req_ready  in / out  1  host read request handshake
host_rd_req_poly, host_rd_req_idx  in  1, max_logn  read target
host_rd_resp_valid / host_rd_resp_ready  out / in  1  host read response handshake
host_rd_resp_data  out  max_logq  response coefficient
err_conflict  out  1  sticky bank-conflict flag

Behaviour:
- Reset (async, rst_n low): r_data_0/1=0, host_wr_ready=0, host_rd_req_ready=0, host_rd_resp_valid=0, host_rd_resp_data=0, err_conflict=0, response buffer emptied. RAM contents are not reset. The state is also cleared by a reset asserted mid-operation; in-flight host reads are dropped.
- Index map: for logical index i, word address = i[max_logn-1:1] and bank = {poly, i[0]}.
- Banks are 1R1W synchronous. A read and a write to the same bank and address in the same cycle return the OLD data (read-before-write). Writes commit at the rising edge when en is high.
- ALU read: when r_en_x is high at edge t, r_data_x is the registered word at t+1. When r_en_x is low, r_data_x holds its previous value.
- Same-bank collision between ports 0 and 1 (two reads, or two writes, to one bank): port 0 is served, port 1 is dropped, and err_conflict is set (see Optional Feature).
- Host gating: host_busy_n = alu_done & ~(r_en_0|r_en_1|w_en_0|w_en_1). The ALU always has priority.
- host_wr_ready = host_busy_n. On a handshake, the write goes through the port-0 path of the target bank.
- Host read path: accepted requests pass through a 2-entry response FIFO.
  - host_rd_req_ready = host_busy_n & (fifo_count + inflight < 2).
  - A request accepted at edge t presents data at t+1 at the earliest.
  - Response data and valid stay stable until host_rd_resp_ready.
  - Simultaneous push and pop keeps the count unchanged. The FIFO pointers wrap modulo 2.
- When alu_done falls with a read in flight, the read still completes and the FIFO drains independently of alu_done.
- A host write and a host read in the same cycle are both accepted. If they target the same coefficient, the read returns old data.

Optional Feature:
NTT_MEM_CONFLICT_CHK_EN
- Defined: err_conflict is set on any same-bank port-0/port-1 collision and on any ALU enable while alu_done=1. It clears only on reset. Simulation builds also emit an $error.
- Undefined: err_conflict is tied to 0, there is no detection logic, and the drop/priority rule is unchanged.

Decomposition:
- Shared package (bp_common_pkg alongside alu_op_e): the ntt_bank_sel_t 2-bit typedef, the NTT_NUM_BANKS=4 constant, and a coeff-to-{bank, addr} mapping function.
- Sub-module ntt_bank_ram: parameterised 1R1W synchronous RAM with read-before-write, instantiated 4 times.

Test Plan:
1. Host writes idx 0..7 of poly 1 with data=idx+100, then reads them back with resp_ready always 1 -> responses 100..107 in order, 1 cycle after each accept, and bank map {1, idx[0]} verified by ALU reads.
2. ALU issues r_en_0 at bank 2/addr 5 in the same cycle as w_en_0 at bank 2/addr 5 with data 0x3 (old value 0x7) -> r_data_0=0x7 next cycle; a re-read returns 0x3.
3. Host issues 3 read requests while resp_ready is held 0 -> 2 accepted, req_ready low on the 3rd. Response data is stable until ready=1, after which the 3rd request is accepted.
4. Host write while alu_done=0, or while r_en_1=1 -> host_wr_ready=0; no write occurs until alu_done=1 and the enables are low.
5. w_en_0 and w_en_1 both target bank 1 with data 0xA/0xB (macro on) -> bank holds 0xA and err_conflict=1, persisting until rst_n pulse. With the macro off, err_conflict stays 0.
6. rst_n is pulsed low with a non-empty response FIFO -> resp_valid=0 and r_data=0 immediately; previously written RAM data is still readable after reset.
